register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 108 ++++++++++
 tb/tb_register_file.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32 x DATA_W general-purpose register file.
// It has two combinational read ports with write bypass, one write port,
// and a debug dump engine. The dump engine streams all 32 registers out
// over a valid/ready handshake.
module register_file #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [32];
  logic              wr_live;
  logic              byp_rs;
  logic              byp_rt;

  // A write counts only outside reset and never to r0.
  // Bypass uses the same qualifier, so reads stay 0 while reset is held.
  assign wr_live = wr_en && !rst && (wr_addr != 5'd0);
  assign byp_rs  = wr_live && (wr_addr == rs_addr);
  assign byp_rt  = wr_live && (wr_addr == rt_addr);

  // Storage: async clear. r0 is never written, so it holds its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: zero latency. A same-cycle write is forwarded to the reader.
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (byp_rs)            rs_data = wr_data;
    if (byp_rt)            rt_data = wr_data;
    if (rs_addr == 5'd0)   rs_data = '0;
    if (rt_addr == 5'd0)   rt_data = '0;
  end

  // Dump beats show stored state only, with no bypass.
  // A stalled beat therefore picks up a write on the cycle after the write.
  assign dump_data = regs[dump_idx];

  // Dump FSM: IDLE -> SEND (32 beats) -> DONE (1 cycle) -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dump_idx   <= 5'd0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= SEND;
            dump_idx   <= 5'd0;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (dump_idx == 5'd31) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx <= dump_idx + 5'd1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_idx  <= 5'd0;
          dump_busy <= 1'b0;
          dump_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed bench for register_file.
// Inputs are driven on the falling edge. Outputs are checked 1ns later.
module tb_register_file;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [4:0]        rs_addr, rt_addr, wr_addr, dump_idx;
  logic [DATA_W-1:0] rs_data, rt_data, wr_data, dump_data;
  logic              wr_en, dump_start, dump_valid, dump_ready, dump_busy, dump_done;

  int tests = 0;
  int fails = 0;

  register_file #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    tests++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_idx !== 5'd0) begin
      fails++;
      $display("FAIL reset_ctl: valid=%b busy=%b done=%b idx=%0d, expected 0 0 0 0",
               dump_valid, dump_busy, dump_done, dump_idx);
    end
    tests++;
    if (rs_data !== '0 || rt_data !== '0) begin
      fails++;
      $display("FAIL reset_read: rs=%h rt=%h, expected 0", rs_data, rt_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    wr_en = 1'b0; rs_addr = 5'd5; rt_addr = 5'd5; #1;
    tests++;
    if (rs_data !== 32'hDEADBEEF || rt_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_rd_r5: rs=%h rt=%h, expected deadbeef", rs_data, rt_data);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    @(negedge clk);
    wr_en = 1'b0; rs_addr = 5'd0; rt_addr = 5'd5; #1;
    tests++;
    if (rs_data !== '0 || rt_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_r0: rs=%h rt=%h, expected 0 / deadbeef", rs_data, rt_data);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rs_addr = 5'd7; rt_addr = 5'd5; #1;
    tests++;
    if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL bypass_rs: rs=%h rt=%h, expected a5a5a5a5 / deadbeef", rs_data, rt_data);
    end
    @(negedge clk);
    wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rt_addr = 5'd0; #1;
    tests++;
    if (rt_data !== '0 || rs_data !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL bypass_r0: rt=%h rs=%h, expected 0 / a5a5a5a5", rt_data, rs_data);
    end
    @(negedge clk);
    wr_addr = 5'd9; wr_data = 32'h0BAD0BAD; rt_addr = 5'd9; rs_addr = 5'd7; #1;
    tests++;
    if (rt_data !== 32'h0BAD0BAD || rs_data !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL bypass_rt: rt=%h rs=%h, expected 0bad0bad / a5a5a5a5", rt_data, rs_data);
    end
    wr_en = 1'b0;
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 3);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_dump_full();
    preload();
    dump_ready = 1'b1; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      #1;
      tests++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_idx !== 5'(b) || dump_data !== 32'(b * 3)) begin
        fails++;
        $display("FAIL dump_beat%0d: valid=%b busy=%b idx=%0d data=%0d, expected 1 1 %0d %0d",
                 b, dump_valid, dump_busy, dump_idx, dump_data, b, b * 3);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (dump_done !== 1'b1 || dump_busy !== 1'b1 || dump_valid !== 1'b0) begin
      fails++;
      $display("FAIL dump_done_cycle33: done=%b busy=%b valid=%b, expected 1 1 0",
               dump_done, dump_busy, dump_valid);
    end
    @(negedge clk); #1;
    tests++;
    if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
      fails++;
      $display("FAIL dump_idle_after: done=%b busy=%b valid=%b, expected 0 0 0",
               dump_done, dump_busy, dump_valid);
    end
  endtask

  task automatic test_dump_stall();
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [4:0] prev_idx   = 5'd0;
    int         exp        = 0;
    bit         seen_done  = 1'b0;
    dump_ready = 1'b0; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      #1;
      if (dump_done) seen_done = 1'b1;
      if (dump_valid && prev_valid && !prev_ready) begin
        tests++;
        if (dump_idx !== prev_idx) begin
          fails++;
          $display("FAIL stall_hold: idx=%0d, expected %0d", dump_idx, prev_idx);
        end
      end
      dump_ready = (c % 2 == 1);
      if (dump_valid && dump_ready) begin
        tests++;
        if (dump_idx !== 5'(exp) || dump_data !== 32'(exp * 3)) begin
          fails++;
          $display("FAIL stall_beat%0d: idx=%0d data=%0d, expected %0d %0d",
                   exp, dump_idx, dump_data, exp, exp * 3);
        end
        exp++;
      end
      prev_valid = dump_valid; prev_ready = dump_ready; prev_idx = dump_idx;
      @(negedge clk);
    end
    tests++;
    if (!seen_done || exp != 32) begin
      fails++;
      $display("FAIL stall_count: beats=%0d done_seen=%0d, expected 32 1", exp, seen_done);
    end
    dump_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall_write();
    bit reached   = 1'b0;
    bit seen_done = 1'b0;
    dump_ready = 1'b1; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int c = 0; c < 60 && !reached; c++) begin
      #1;
      if (dump_valid && dump_idx == 5'd10) begin
        reached = 1'b1;
        dump_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    tests++;
    if (!reached) begin
      fails++;
      $display("FAIL sw_reach: never saw idx 10, idx=%0d", dump_idx);
    end
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hFFFF; #1;
    tests++;
    if (dump_data !== 32'd30) begin
      fails++;
      $display("FAIL sw_no_bypass: data=%h, expected 1e", dump_data);
    end
    @(negedge clk);
    wr_en = 1'b0; #1;
    tests++;
    if (dump_data !== 32'hFFFF || dump_idx !== 5'd10) begin
      fails++;
      $display("FAIL sw_update: data=%h idx=%0d, expected ffff 10", dump_data, dump_idx);
    end
    dump_ready = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (dump_idx !== 5'd11 || dump_data !== 32'd33) begin
      fails++;
      $display("FAIL sw_advance: idx=%0d data=%0d, expected 11 33", dump_idx, dump_data);
    end
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk); #1;
      if (dump_done) seen_done = 1'b1;
    end
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL sw_finish: no dump_done within bound");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_dump();
    bit reached = 1'b0;
    bit done_hi = 1'b0;
    dump_ready = 1'b1; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int c = 0; c < 60 && !reached; c++) begin
      #1;
      if (dump_valid && dump_idx == 5'd12) reached = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!reached) begin
      fails++;
      $display("FAIL rm_reach: never saw idx 12");
    end
    #1;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    rs_addr = 5'd3; rt_addr = 5'd10;
    #1;
    tests++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_done !== 1'b0) begin
      fails++;
      $display("FAIL rm_async: valid=%b busy=%b idx=%0d done=%b, expected 0 0 0 0",
               dump_valid, dump_busy, dump_idx, dump_done);
    end
    tests++;
    if (rs_data !== '0 || rt_data !== '0) begin
      fails++;
      $display("FAIL rm_reads: rs=%h rt=%h, expected 0 0", rs_data, rt_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (dump_done) done_hi = 1'b1;
    end
    rst = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (dump_done) done_hi = 1'b1;
    end
    tests++;
    if (done_hi || rs_data !== '0) begin
      fails++;
      $display("FAIL rm_no_done: done_seen=%0d r3=%h, expected 0 0", done_hi, rs_data);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    @(negedge clk);
    wr_en = 1'b0; #1;
    tests++;
    if (rs_data !== 32'h55) begin
      fails++;
      $display("FAIL rm_first_write: r3=%h, expected 55", rs_data);
    end
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; #1;
    tests++;
    if (dump_valid !== 1'b1 || dump_idx !== 5'd0 || dump_data !== '0) begin
      fails++;
      $display("FAIL rm_restart: valid=%b idx=%0d data=%h, expected 1 0 0",
               dump_valid, dump_idx, dump_data);
    end
    @(negedge clk); #1;
    tests++;
    if (dump_idx !== 5'd1 || dump_data !== '0) begin
      fails++;
      $display("FAIL rm_cleared: idx=%0d data=%h, expected 1 0", dump_idx, dump_data);
    end
  endtask

  initial begin
    rst = 1'b1; rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0;
    wr_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_dump_full();
    test_dump_stall();
    test_stall_write();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
